// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op codes, operand selects and the
// ID/EX control bundle carried across the pipeline boundary.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Encoding is fixed by the EX-stage ALU; do not renumber.
    localparam logic [3:0] ULA_ADD  = 4'b0000;
    localparam logic [3:0] ULA_SUB  = 4'b0001;
    localparam logic [3:0] ULA_XOR  = 4'b0010;
    localparam logic [3:0] ULA_OR   = 4'b0011;
    localparam logic [3:0] ULA_AND  = 4'b0100;
    localparam logic [3:0] ULA_SLL  = 4'b0101;
    localparam logic [3:0] ULA_SRL  = 4'b0110;
    localparam logic [3:0] ULA_SRA  = 4'b0111;
    localparam logic [3:0] ULA_SLT  = 4'b1000;
    localparam logic [3:0] ULA_SLTU = 4'b1001;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;
    localparam logic       SRC_B_RS2  = 1'b0;
    localparam logic       SRC_B_IMM  = 1'b1;

    typedef struct packed {
        logic        illegal;
        logic [3:0]  ula_op;
        logic [1:0]  src_a;
        logic        src_b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        br_invert;
        logic        jump;
        logic        jalr;
    } ctrl_t;

    // alt selects SUB/SRA; callers must only assert it where that is legal.
    function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ULA_SUB : ULA_ADD;
            3'b001:  return ULA_SLL;
            3'b010:  return ULA_SLT;
            3'b011:  return ULA_SLTU;
            3'b100:  return ULA_XOR;
            3'b101:  return alt ? ULA_SRA : ULA_SRL;
            3'b110:  return ULA_OR;
            default: return ULA_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I instruction decoder producing the ID/EX control bundle.
// Unsupported encodings collapse to an all-zero bundle with only illegal set.
import rv32i_pkg::*;

module rv32i_decoder (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        case (opcode)
            OP_REG: begin
                legal          = (f7 == F7_BASE) ||
                                 ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                ctrl.ula_op    = alu_op_from_f3(f3, f7 == F7_ALT);
                ctrl.src_b     = SRC_B_RS2;
                ctrl.rs1       = rs1;
                ctrl.rs2       = rs2;
                ctrl.rd        = rd;
                ctrl.funct3    = f3;
                ctrl.reg_write = (rd != 5'd0);
            end
            OP_IMM: begin
                if (f3 == 3'b001)
                    legal = (f7 == F7_BASE);
                else if (f3 == 3'b101)
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    legal = 1'b1;
                // Only the shift-right form uses funct7; ADDI with bit 30 set stays ADD.
                ctrl.ula_op    = alu_op_from_f3(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                ctrl.imm       = ((f3 == 3'b001) || (f3 == 3'b101)) ? {27'b0, instr[24:20]} : imm_i;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.rs1       = rs1;
                ctrl.rd        = rd;
                ctrl.funct3    = f3;
                ctrl.reg_write = (rd != 5'd0);
            end
            OP_LOAD: begin
                legal          = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                ctrl.ula_op    = ULA_ADD;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.imm       = imm_i;
                ctrl.rs1       = rs1;
                ctrl.rd        = rd;
                ctrl.funct3    = f3;
                ctrl.reg_write = (rd != 5'd0);
                ctrl.mem_read  = 1'b1;
            end
            OP_STORE: begin
                legal          = (f3 inside {3'b000, 3'b001, 3'b010});
                ctrl.ula_op    = ULA_ADD;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.imm       = imm_s;
                ctrl.rs1       = rs1;
                ctrl.rs2       = rs2;
                ctrl.funct3    = f3;
                ctrl.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                legal       = (f3 != 3'b010) && (f3 != 3'b011);
                ctrl.imm    = imm_b;
                ctrl.rs1    = rs1;
                ctrl.rs2    = rs2;
                ctrl.funct3 = f3;
                ctrl.branch = 1'b1;
                // Taken = branch & (zero ^ br_invert)
                case (f3)
                    3'b000:  begin ctrl.ula_op = ULA_SUB;  ctrl.br_invert = 1'b0; end
                    3'b001:  begin ctrl.ula_op = ULA_SUB;  ctrl.br_invert = 1'b1; end
                    3'b100:  begin ctrl.ula_op = ULA_SLT;  ctrl.br_invert = 1'b1; end
                    3'b101:  begin ctrl.ula_op = ULA_SLT;  ctrl.br_invert = 1'b0; end
                    3'b110:  begin ctrl.ula_op = ULA_SLTU; ctrl.br_invert = 1'b1; end
                    3'b111:  begin ctrl.ula_op = ULA_SLTU; ctrl.br_invert = 1'b0; end
                    default: begin ctrl.ula_op = ULA_ADD;  ctrl.br_invert = 1'b0; end
                endcase
            end
            OP_LUI: begin
                legal          = 1'b1;
                ctrl.ula_op    = ULA_ADD;
                ctrl.src_a     = SRC_A_ZERO;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.imm       = imm_u;
                ctrl.rd        = rd;
                ctrl.reg_write = (rd != 5'd0);
            end
            OP_AUIPC: begin
                legal          = 1'b1;
                ctrl.ula_op    = ULA_ADD;
                ctrl.src_a     = SRC_A_PC;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.imm       = imm_u;
                ctrl.rd        = rd;
                ctrl.reg_write = (rd != 5'd0);
            end
            OP_JAL: begin
                // ex_imm carries the J offset so the branch unit can form pc + offset.
                legal          = 1'b1;
                ctrl.ula_op    = ULA_ADD;
                ctrl.src_a     = SRC_A_PC;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.imm       = imm_j;
                ctrl.rd        = rd;
                ctrl.reg_write = (rd != 5'd0);
                ctrl.jump      = 1'b1;
            end
            OP_JALR: begin
                legal          = (f3 == 3'b000);
                ctrl.ula_op    = ULA_ADD;
                ctrl.src_a     = SRC_A_RS1;
                ctrl.src_b     = SRC_B_IMM;
                ctrl.imm       = imm_i;
                ctrl.rs1       = rs1;
                ctrl.rd        = rd;
                ctrl.funct3    = f3;
                ctrl.reg_write = (rd != 5'd0);
                ctrl.jump      = 1'b1;
                ctrl.jalr      = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/idex_decode_stage.sv
// ID-stage decode plus the ID/EX pipeline register, with hazard-unit stall
// (hold) and flush (bubble) control. Priority: reset > flush > stall > load.
import rv32i_pkg::*;

module idex_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [3:0]      ex_ula_op,
    output logic [1:0]      ex_src_a,
    output logic            ex_src_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_br_invert,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    ctrl_t           dec_ctrl;
    ctrl_t           ctrl_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;

    rv32i_decoder u_decoder (
        .instr (id_instr),
        .ctrl  (dec_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= RESET_PC;
        end else if (!stall) begin
            if (id_valid) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec_ctrl;
                pc_q    <= id_pc;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                pc_q    <= RESET_PC;
            end
        end
    end

    assign ex_valid     = valid_q;
    assign ex_ula_op    = ctrl_q.ula_op;
    assign ex_src_a     = ctrl_q.src_a;
    assign ex_src_b     = ctrl_q.src_b;
    assign ex_imm       = ctrl_q.imm;
    assign ex_rs1       = ctrl_q.rs1;
    assign ex_rs2       = ctrl_q.rs2;
    assign ex_rd        = ctrl_q.rd;
    assign ex_funct3    = ctrl_q.funct3;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_branch    = ctrl_q.branch;
    assign ex_br_invert = ctrl_q.br_invert;
    assign ex_jump      = ctrl_q.jump;
    assign ex_jalr      = ctrl_q.jalr;
    assign ex_pc        = pc_q;
    assign ex_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_idex_decode_stage.sv
// Directed-vector bench for idex_decode_stage: reset, decode of each RV32I base
// instruction, illegal encodings and stall/flush/bubble behaviour.
module tb_idex_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_ula_op;
    logic [1:0]  ex_src_a;
    logic        ex_src_b;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_br_invert;
    logic        ex_jump;
    logic        ex_jalr;
    logic [31:0] ex_pc;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idex_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ula_op    (ex_ula_op),
        .ex_src_a     (ex_src_a),
        .ex_src_b     (ex_src_b),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_funct3    (ex_funct3),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_branch    (ex_branch),
        .ex_br_invert (ex_br_invert),
        .ex_jump      (ex_jump),
        .ex_jalr      (ex_jalr),
        .ex_pc        (ex_pc),
        .ex_illegal   (ex_illegal)
    );

    // Instruction assemblers: build encodings from chosen fields.
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_valid = 1'b1; id_instr = 32'h002081B3; id_pc = 32'h40;
        stall = 1'b0; flush = 1'b0;
        step(); step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
        checks++; if (ex_ula_op !== 4'b0000) begin errors++; $display("FAIL reset_ula got %h want 0", ex_ula_op); end
        checks++; if (ex_pc !== RST_PC) begin errors++; $display("FAIL reset_pc got %h want %h", ex_pc, RST_PC); end
        checks++; if (ex_rd !== 5'd0 || ex_reg_write !== 1'b0 || ex_illegal !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl rd %0d rw %0b ill %0b want 0/0/0", ex_rd, ex_reg_write, ex_illegal); end
        rst_n = 1'b1;
        #2;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL release_early got %0b want 0", ex_valid); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h40)
            begin errors++; $display("FAIL release_first valid %0b pc %h want 1/00000040", ex_valid, ex_pc); end
    endtask

    task automatic test_alu_ops();
        id_instr = 32'h002081B3; id_pc = 32'h44;
        step();
        checks++; if (ex_ula_op !== 4'b0000 || ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2 || ex_rd !== 5'd3)
            begin errors++; $display("FAIL add_fields ula %h rs1 %0d rs2 %0d rd %0d want 0/1/2/3", ex_ula_op, ex_rs1, ex_rs2, ex_rd); end
        checks++; if (ex_reg_write !== 1'b1 || ex_src_b !== 1'b0 || ex_src_a !== 2'b00)
            begin errors++; $display("FAIL add_ctrl rw %0b srcb %0b srca %b want 1/0/00", ex_reg_write, ex_src_b, ex_src_a); end
        id_instr = 32'h402081B3;
        step();
        checks++; if (ex_ula_op !== 4'b0001 || ex_rd !== 5'd3)
            begin errors++; $display("FAIL sub ula %h rd %0d want 1/3", ex_ula_op, ex_rd); end
        id_instr = 32'h40335293;
        step();
        checks++; if (ex_ula_op !== 4'b0111 || ex_imm !== 32'd3 || ex_src_b !== 1'b1 || ex_rs1 !== 5'd6 || ex_rd !== 5'd5)
            begin errors++; $display("FAIL srai ula %h imm %h srcb %0b rs1 %0d rd %0d want 7/3/1/6/5", ex_ula_op, ex_imm, ex_src_b, ex_rs1, ex_rd); end
    endtask

    task automatic test_branch();
        id_instr = 32'hFE20CCE3;
        step();
        checks++; if (ex_ula_op !== 4'b1000 || ex_imm !== 32'hFFFFFFF8)
            begin errors++; $display("FAIL blt_op ula %h imm %h want 8/fffffff8", ex_ula_op, ex_imm); end
        checks++; if (ex_branch !== 1'b1 || ex_br_invert !== 1'b1 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0)
            begin errors++; $display("FAIL blt_ctrl br %0b inv %0b rw %0b rd %0d want 1/1/0/0", ex_branch, ex_br_invert, ex_reg_write, ex_rd); end
        checks++; if (ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2 || ex_funct3 !== 3'b100)
            begin errors++; $display("FAIL blt_regs rs1 %0d rs2 %0d f3 %b want 1/2/100", ex_rs1, ex_rs2, ex_funct3); end
    endtask

    task automatic test_lui_illegal();
        id_instr = 32'h123450B7;
        step();
        checks++; if (ex_ula_op !== 4'b0000 || ex_src_a !== 2'b10 || ex_imm !== 32'h12345000 || ex_rd !== 5'd1)
            begin errors++; $display("FAIL lui ula %h srca %b imm %h rd %0d want 0/10/12345000/1", ex_ula_op, ex_src_a, ex_imm, ex_rd); end
        id_instr = 32'hFFFFFFFF;
        step();
        checks++; if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0)
            begin errors++; $display("FAIL illegal_ff ill %0b v %0b rw %0b mr %0b mw %0b want 1/1/0/0/0", ex_illegal, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write); end
        id_instr = enc_i(12'h010, 5'd1, 3'b000, 5'd0, 7'b0010011);
        step();
        checks++; if (ex_reg_write !== 1'b0 || ex_illegal !== 1'b0)
            begin errors++; $display("FAIL rd0_nowrite rw %0b ill %0b want 0/0", ex_reg_write, ex_illegal); end
    endtask

    task automatic test_stall();
        id_instr = 32'h002081B3; id_pc = 32'h80;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_instr = 32'h123450B7 + 32'(i); id_pc = 32'h90 + 32'(4 * i);
            step();
            checks++; if (ex_valid !== 1'b1 || ex_ula_op !== 4'b0000 || ex_rd !== 5'd3 || ex_pc !== 32'h80 || ex_src_a !== 2'b00)
                begin errors++; $display("FAIL stall_hold%0d v %0b ula %h rd %0d pc %h srca %b want 1/0/3/80/00", i, ex_valid, ex_ula_op, ex_rd, ex_pc, ex_src_a); end
        end
        stall = 1'b0; id_instr = 32'h123450B7; id_pc = 32'h9C;
        step();
        checks++; if (ex_src_a !== 2'b10 || ex_pc !== 32'h9C)
            begin errors++; $display("FAIL stall_release srca %b pc %h want 10/9c", ex_src_a, ex_pc); end
    endtask

    task automatic test_flush();
        stall = 1'b1; flush = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_pc !== RST_PC || ex_rd !== 5'd0 || ex_src_a !== 2'b00 || ex_imm !== 32'd0)
            begin errors++; $display("FAIL flush_stall v %0b pc %h rd %0d srca %b imm %h want bubble", ex_valid, ex_pc, ex_rd, ex_src_a, ex_imm); end
        stall = 1'b0; flush = 1'b0; id_instr = 32'h002081B3; id_pc = 32'hA0;
        step();
        id_valid = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_pc !== RST_PC || ex_rs1 !== 5'd0)
            begin errors++; $display("FAIL novalid_bubble v %0b rw %0b pc %h rs1 %0d want 0/0/100/0", ex_valid, ex_reg_write, ex_pc, ex_rs1); end
        id_valid = 1'b1;
        step();
        stall = 1'b1; rst_n = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_pc !== RST_PC)
            begin errors++; $display("FAIL reset_mid_stall v %0b pc %h want 0/100", ex_valid, ex_pc); end
        stall = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        id_instr = 32'h002081B3; id_pc = 32'h200;
        step();
        checks++; if (ex_ula_op !== 4'b0000 || ex_pc !== 32'h200 || ex_valid !== 1'b1)
            begin errors++; $display("FAIL b2b_first ula %h pc %h v %0b want 0/200/1", ex_ula_op, ex_pc, ex_valid); end
        id_instr = 32'h402081B3; id_pc = 32'h204;
        step();
        checks++; if (ex_ula_op !== 4'b0001 || ex_pc !== 32'h204)
            begin errors++; $display("FAIL b2b_second ula %h pc %h want 1/204", ex_ula_op, ex_pc); end
    endtask

    task automatic test_sweep();
        logic [31:0] ins [37];
        logic [3:0]  ula [37];
        logic [31:0] imm [37];
        logic [31:0] bad [10];
        ins[0]  = {20'h12345, 5'd1, 7'b0110111};            ula[0]  = 4'd0; imm[0]  = 32'h12345000;
        ins[1]  = {20'hFFFFF, 5'd2, 7'b0010111};            ula[1]  = 4'd0; imm[1]  = 32'hFFFFF000;
        ins[2]  = enc_j(21'h1FFFF0, 5'd1);                   ula[2]  = 4'd0; imm[2]  = 32'hFFFFFFF0;
        ins[3]  = enc_i(12'h004, 5'd1, 3'b000, 5'd1, 7'b1100111); ula[3] = 4'd0; imm[3] = 32'h4;
        ins[4]  = enc_b(13'h0010, 5'd2, 5'd1, 3'b000);       ula[4]  = 4'd1; imm[4]  = 32'h10;
        ins[5]  = enc_b(13'h1FFC, 5'd2, 5'd1, 3'b001);       ula[5]  = 4'd1; imm[5]  = 32'hFFFFFFFC;
        ins[6]  = enc_b(13'h0800, 5'd2, 5'd1, 3'b100);       ula[6]  = 4'd8; imm[6]  = 32'h800;
        ins[7]  = enc_b(13'h1000, 5'd2, 5'd1, 3'b101);       ula[7]  = 4'd8; imm[7]  = 32'hFFFFF000;
        ins[8]  = enc_b(13'h0008, 5'd2, 5'd1, 3'b110);       ula[8]  = 4'd9; imm[8]  = 32'h8;
        ins[9]  = enc_b(13'h0FFE, 5'd2, 5'd1, 3'b111);       ula[9]  = 4'd9; imm[9]  = 32'hFFE;
        ins[10] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd3, 7'b0000011); ula[10] = 4'd0; imm[10] = 32'hFFFFFFFF;
        ins[11] = enc_i(12'h010, 5'd1, 3'b001, 5'd3, 7'b0000011); ula[11] = 4'd0; imm[11] = 32'h10;
        ins[12] = enc_i(12'h7FF, 5'd1, 3'b010, 5'd3, 7'b0000011); ula[12] = 4'd0; imm[12] = 32'h7FF;
        ins[13] = enc_i(12'h800, 5'd1, 3'b100, 5'd3, 7'b0000011); ula[13] = 4'd0; imm[13] = 32'hFFFFF800;
        ins[14] = enc_i(12'h001, 5'd1, 3'b101, 5'd3, 7'b0000011); ula[14] = 4'd0; imm[14] = 32'h1;
        ins[15] = enc_s(12'h020, 5'd2, 5'd1, 3'b000);        ula[15] = 4'd0; imm[15] = 32'h20;
        ins[16] = enc_s(12'hFFE, 5'd2, 5'd1, 3'b001);        ula[16] = 4'd0; imm[16] = 32'hFFFFFFFE;
        ins[17] = enc_s(12'h7E1, 5'd2, 5'd1, 3'b010);        ula[17] = 4'd0; imm[17] = 32'h7E1;
        ins[18] = enc_i(12'h400, 5'd1, 3'b000, 5'd3, 7'b0010011); ula[18] = 4'd0; imm[18] = 32'h400;
        ins[19] = enc_i(12'hFFF, 5'd1, 3'b010, 5'd3, 7'b0010011); ula[19] = 4'd8; imm[19] = 32'hFFFFFFFF;
        ins[20] = enc_i(12'h005, 5'd1, 3'b011, 5'd3, 7'b0010011); ula[20] = 4'd9; imm[20] = 32'h5;
        ins[21] = enc_i(12'h0AA, 5'd1, 3'b100, 5'd3, 7'b0010011); ula[21] = 4'd2; imm[21] = 32'hAA;
        ins[22] = enc_i(12'h800, 5'd1, 3'b110, 5'd3, 7'b0010011); ula[22] = 4'd3; imm[22] = 32'hFFFFF800;
        ins[23] = enc_i(12'h0FF, 5'd1, 3'b111, 5'd3, 7'b0010011); ula[23] = 4'd4; imm[23] = 32'hFF;
        ins[24] = enc_i(12'h01F, 5'd1, 3'b001, 5'd3, 7'b0010011); ula[24] = 4'd5; imm[24] = 32'd31;
        ins[25] = enc_i(12'h005, 5'd1, 3'b101, 5'd3, 7'b0010011); ula[25] = 4'd6; imm[25] = 32'd5;
        ins[26] = enc_i(12'h403, 5'd1, 3'b101, 5'd3, 7'b0010011); ula[26] = 4'd7; imm[26] = 32'd3;
        ins[27] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);    ula[27] = 4'd0; imm[27] = 32'd0;
        ins[28] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);    ula[28] = 4'd1; imm[28] = 32'd0;
        ins[29] = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3);    ula[29] = 4'd5; imm[29] = 32'd0;
        ins[30] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3);    ula[30] = 4'd8; imm[30] = 32'd0;
        ins[31] = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3);    ula[31] = 4'd9; imm[31] = 32'd0;
        ins[32] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3);    ula[32] = 4'd2; imm[32] = 32'd0;
        ins[33] = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3);    ula[33] = 4'd6; imm[33] = 32'd0;
        ins[34] = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3);    ula[34] = 4'd7; imm[34] = 32'd0;
        ins[35] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3);    ula[35] = 4'd3; imm[35] = 32'd0;
        ins[36] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3);    ula[36] = 4'd4; imm[36] = 32'd0;

        bad[0] = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3);
        bad[1] = enc_r(7'h20, 5'd2, 5'd1, 3'b100, 5'd3);
        bad[2] = enc_i(12'h401, 5'd1, 3'b001, 5'd3, 7'b0010011);
        bad[3] = enc_i(12'h021, 5'd1, 3'b101, 5'd3, 7'b0010011);
        bad[4] = enc_b(13'h0010, 5'd2, 5'd1, 3'b010);
        bad[5] = enc_b(13'h0010, 5'd2, 5'd1, 3'b011);
        bad[6] = 32'h0000000F;
        bad[7] = enc_i(12'h004, 5'd1, 3'b001, 5'd1, 7'b1100111);
        bad[8] = enc_i(12'h004, 5'd1, 3'b011, 5'd3, 7'b0000011);
        bad[9] = enc_s(12'h004, 5'd2, 5'd1, 3'b011);

        for (int i = 0; i < 37; i++) begin
            id_instr = ins[i]; id_pc = 32'h1000 + 32'(4 * i);
            step();
            checks++; if (ex_ula_op !== ula[i] || ex_imm !== imm[i] || ex_illegal !== 1'b0 || ex_valid !== 1'b1)
                begin errors++; $display("FAIL sweep%0d instr %h ula %h imm %h ill %0b want %h/%h/0", i, ins[i], ex_ula_op, ex_imm, ex_illegal, ula[i], imm[i]); end
        end
        for (int i = 0; i < 10; i++) begin
            id_instr = bad[i];
            step();
            checks++; if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 || ex_ula_op !== 4'b0000 ||
                          ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0 ||
                          ex_branch !== 1'b0 || ex_jump !== 1'b0 || ex_jalr !== 1'b0)
                begin errors++; $display("FAIL illegal%0d instr %h ill %0b v %0b ula %h rw %0b mr %0b mw %0b br %0b j %0b want 1/1/0/0/0/0/0/0", i, bad[i], ex_illegal, ex_valid, ex_ula_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_lui_illegal();
        test_stall();
        test_flush();
        test_back_to_back();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
